// File: rtl/mips32_hazard_ctrl.sv
// RAW interlock for the 5-stage MIPS32 pipeline: holds IF/ID and bubbles EX until ID sources are written back.
// Stall/bubble are combinational from ID decode and a 3-entry destination shift register; freeze and count are registered.
module mips32_hazard_ctrl #(
  parameter int CW   = 16,
  parameter int NREG = 32
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [31:0]   id_ir,
  input  logic          flush,
  output logic          stall_id,
  output logic          ex_bubble,
  output logic          fetch_freeze,
  output logic [CW-1:0] stall_count
);
  localparam int RW = $clog2(NREG);

  logic [5:0]    opc;
  logic [RW-1:0] rs, rt, rd;
  logic          rd_rs, rd_rt, wr_en;
  logic [RW-1:0] wr_dst;

  logic          ex_v_q, mem_v_q, wb_v_q;
  logic [RW-1:0] ex_dst_q, mem_dst_q, wb_dst_q;
  logic          ex_v_d, mem_v_d, wb_v_d;
  logic [RW-1:0] ex_dst_d, mem_dst_d, wb_dst_d;
  logic          freeze_q, freeze_d;
  logic [CW-1:0] count_q, count_d;

  logic match_rs, match_rt, hazard, issue;
  logic unused_ir_bits;

  assign opc = id_ir[31:26];
  assign rs  = id_ir[21 +: RW];
  assign rt  = id_ir[16 +: RW];
  assign rd  = id_ir[11 +: RW];
  assign unused_ir_bits = ^id_ir[10:0];

  always_comb begin
    rd_rs  = 1'b0;
    rd_rt  = 1'b0;
    wr_en  = 1'b0;
    wr_dst = '0;
    case (opc) inside
      [6'd0:6'd5]:   begin rd_rs = 1'b1; rd_rt = 1'b1; wr_en = 1'b1; wr_dst = rd; end
      [6'd10:6'd12]: begin rd_rs = 1'b1; wr_en = 1'b1; wr_dst = rt; end
      6'd8:          begin rd_rs = 1'b1; wr_en = 1'b1; wr_dst = rt; end
      6'd9:          begin rd_rs = 1'b1; rd_rt = 1'b1; end
      6'd13, 6'd14:  rd_rs = 1'b1;
      default:       ;
    endcase
  end

  // R0 is hardwired zero, so it can never be the subject of a RAW hazard.
  assign match_rs = rd_rs && (rs != '0) &&
                    ((ex_v_q && ex_dst_q == rs) || (mem_v_q && mem_dst_q == rs) ||
                     (wb_v_q && wb_dst_q == rs));
  assign match_rt = rd_rt && (rt != '0) &&
                    ((ex_v_q && ex_dst_q == rt) || (mem_v_q && mem_dst_q == rt) ||
                     (wb_v_q && wb_dst_q == rt));

  assign hazard    = id_valid && (match_rs || match_rt);
  assign stall_id  = hazard && !flush;
  assign ex_bubble = stall_id;
  assign issue     = id_valid && !stall_id && !flush;

  always_comb begin
    ex_v_d    = issue && wr_en && (wr_dst != '0);
    ex_dst_d  = wr_dst;
    // A taken branch kills the instruction currently in EX; WB still retires normally.
    mem_v_d   = ex_v_q && !flush;
    mem_dst_d = ex_dst_q;
    wb_v_d    = mem_v_q;
    wb_dst_d  = mem_dst_q;
    freeze_d  = freeze_q || (issue && opc == 6'h3f);
    count_d   = count_q;
    if (stall_id && count_q != {CW{1'b1}})
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      ex_v_q    <= 1'b0;
      mem_v_q   <= 1'b0;
      wb_v_q    <= 1'b0;
      ex_dst_q  <= '0;
      mem_dst_q <= '0;
      wb_dst_q  <= '0;
      freeze_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      ex_v_q    <= ex_v_d;
      mem_v_q   <= mem_v_d;
      wb_v_q    <= wb_v_d;
      ex_dst_q  <= ex_dst_d;
      mem_dst_q <= mem_dst_d;
      wb_dst_q  <= wb_dst_d;
      freeze_q  <= freeze_d;
      count_q   <= count_d;
    end
  end

  assign fetch_freeze = freeze_q;
  assign stall_count  = count_q;
endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Directed-vector bench with an expected-response queue drained by an independent monitor.
module tb_mips32_hazard_ctrl;
  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] id_ir = 32'h0;
  logic        stall_id, ex_bubble, fetch_freeze;
  logic [15:0] stall_count;
  logic        stall_id2, ex_bubble2, fetch_freeze2;
  logic [1:0]  stall_count2;

  mips32_hazard_ctrl dut (
    .clk1(clk1), .rst(rst), .id_valid(id_valid), .id_ir(id_ir), .flush(flush),
    .stall_id(stall_id), .ex_bubble(ex_bubble), .fetch_freeze(fetch_freeze),
    .stall_count(stall_count)
  );

  mips32_hazard_ctrl #(.CW(2)) dut2 (
    .clk1(clk1), .rst(rst), .id_valid(id_valid), .id_ir(id_ir), .flush(flush),
    .stall_id(stall_id2), .ex_bubble(ex_bubble2), .fetch_freeze(fetch_freeze2),
    .stall_count(stall_count2)
  );

  always #5 clk1 = ~clk1;

  localparam logic [31:0] ADDI_R2   = 32'h28020014;
  localparam logic [31:0] ADDI_R1   = 32'h2801000a;
  localparam logic [31:0] ADDI_R3   = 32'h28030007;
  localparam logic [31:0] ADDI_R0   = 32'h28000005;
  localparam logic [31:0] ADD_4_1_2 = 32'h00222000;
  localparam logic [31:0] ADD_4_0_0 = 32'h00002000;
  localparam logic [31:0] ADD_6_2_2 = 32'h00423000;
  localparam logic [31:0] ADD_6_2_3 = 32'h00433000;
  localparam logic [31:0] ADD_8_4_4 = 32'h00844000;
  localparam logic [31:0] OR_7_3_3  = 32'h0c633800;
  localparam logic [31:0] LW_3_R1   = 32'h20230000;
  localparam logic [31:0] SW_3_R5   = 32'h24a30000;
  localparam logic [31:0] SW_5_R3   = 32'h24650000;
  localparam logic [31:0] BEQZ_R2   = 32'h38400000;
  localparam logic [31:0] HLT       = 32'hfc000000;

  typedef struct {
    logic        r;
    logic        vld;
    logic [31:0] ir;
    logic        fl;
    logic        stall;
  } vec_t;

  typedef struct {
    int          step;
    logic        stall;
    logic        freeze;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic vld, input logic [31:0] ir,
                     input logic fl, input logic st);
    vec_t x;
    x.r = r; x.vld = vld; x.ir = ir; x.fl = fl; x.stall = st;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input int step, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, step, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_id",      e.step, 32'(stall_id),      32'(e.stall));
        check("ex_bubble",     e.step, 32'(ex_bubble),     32'(e.stall));
        check("fetch_freeze",  e.step, 32'(fetch_freeze),  32'(e.freeze));
        check("stall_count",   e.step, 32'(stall_count),   32'(e.cnt));
        check("stall_count2",  e.step, 32'(stall_count2),  32'(e.cnt2));
      end
    end
  end

  initial begin : driver
    logic        freeze_m;
    int          cnt_m;
    int          cnt2_m;
    exp_t        e;
    freeze_m = 1'b0; cnt_m = 0; cnt2_m = 0;

    add(1, 0, 32'h0, 0, 0);
    add(1, 0, 32'h0, 0, 0);
    add(0, 0, 32'h0, 0, 0);
    // back-to-back dependency: three interlock cycles
    add(0, 1, ADDI_R2, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, ADD_4_1_2, 0, 1);
    add(0, 1, ADD_4_1_2, 0, 0);
    // producer far enough back: no interlock
    add(0, 1, ADDI_R1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, OR_7_3_3, 0, 0);
    add(0, 1, ADD_4_1_2, 0, 0);
    // R0 never hazards
    add(0, 1, ADDI_R0, 0, 0);
    add(0, 1, ADD_4_0_0, 0, 0);
    // load feeding store data through rt
    add(0, 1, LW_3_R1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, SW_3_R5, 0, 1);
    add(0, 1, SW_3_R5, 0, 0);
    // stores write nothing
    add(0, 1, SW_5_R3, 0, 0);
    add(0, 1, SW_3_R5, 0, 0);
    // branch source
    add(0, 1, ADDI_R2, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, BEQZ_R2, 0, 1);
    add(0, 1, BEQZ_R2, 0, 0);
    // flush beats hazard and removes the EX entry; squashed ADD leaves no R4 entry
    add(0, 1, ADDI_R2, 0, 0);
    add(0, 1, ADD_4_1_2, 1, 0);
    add(0, 1, ADD_6_2_2, 0, 0);
    add(0, 1, ADD_8_4_4, 0, 0);
    // flush kills EX->MEM but MEM->WB still retires
    add(0, 1, ADDI_R2, 0, 0);
    add(0, 1, ADDI_R3, 0, 0);
    add(0, 0, 32'h0, 1, 0);
    add(0, 1, ADD_6_2_3, 0, 1);
    add(0, 1, ADD_6_2_3, 0, 0);
    // reset in the middle of a stall
    add(0, 1, ADDI_R2, 0, 0);
    add(1, 1, ADD_4_1_2, 0, 1);
    add(0, 1, ADD_4_1_2, 0, 0);
    add(0, 0, 32'h0, 0, 0);
    // HLT freezes fetch until reset
    add(0, 1, HLT, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 32'h0, 0, 0);
    add(1, 0, 32'h0, 0, 0);
    add(0, 0, 32'h0, 0, 0);
    add(0, 0, 32'h0, 0, 0);

    foreach (vecs[i]) begin
      @(posedge clk1);
      #1;
      rst      = vecs[i].r;
      id_valid = vecs[i].vld;
      id_ir    = vecs[i].ir;
      flush    = vecs[i].fl;
      e.step   = i;
      e.stall  = vecs[i].stall;
      e.freeze = freeze_m;
      e.cnt    = 16'(cnt_m);
      e.cnt2   = 2'(cnt2_m);
      exp_q.push_back(e);
      if (vecs[i].r) begin
        freeze_m = 1'b0; cnt_m = 0; cnt2_m = 0;
      end else begin
        if (vecs[i].stall) begin
          if (cnt_m < 65535) cnt_m++;
          if (cnt2_m < 3) cnt2_m++;
        end
        if (vecs[i].vld && vecs[i].ir[31:26] == 6'h3f && !vecs[i].stall && !vecs[i].fl)
          freeze_m = 1'b1;
      end
    end

    repeat (4) @(posedge clk1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
